misr_checker: RTL

- Multiple-input signature register (MISR) response compactor; the receive-side counterpart of the LFSR stimulus generator.
- Sits at the systolic-array output and folds each valid result word into a running signature.
- On the last beat it compares the signature against an expected value and reports pass/fail.
- Uses the same XNOR tap convention as the stimulus LFSR, so golden signatures come from the same software model.

---
 rtl/misr_checker.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/misr_checker.sv
// misr_checker: multiple-input signature register response compactor.
// Folds every valid result word into a running signature and, on the
// last beat, compares that signature against a golden value.
// Optional idle-beat watchdog enabled with the macro MISR_TIMEOUT_EN.
module misr_checker #(
    parameter int NUM_BITS       = 49,
    parameter int TAP_LO         = 40,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic [NUM_BITS-1:0] i_seed,
    input  logic                i_vld,
    input  logic [NUM_BITS-1:0] i_data,
    input  logic                i_last,
    input  logic [NUM_BITS-1:0] i_expected,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_pass,
    output logic [NUM_BITS-1:0] o_signature,
    output logic [CNT_W-1:0]    o_count,
    output logic                o_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_CHECK,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_BITS-1:0] sig_q, sig_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic                timeout_q, timeout_d;
    logic                fb;
    logic [NUM_BITS-1:0] sig_next;
    logic                idle_expired;

    // Signature update: shift toward the top bit, XNOR feedback into bit 1,
    // then fold the incoming word in. sig[k] lives at sig_q[k-1].
    always_comb begin
        fb       = ~(sig_q[NUM_BITS-1] ^ sig_q[TAP_LO-1]);
        sig_next = {sig_q[NUM_BITS-2:0], fb} ^ i_data;
    end

`ifdef MISR_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [IDLE_W-1:0] idle_q, idle_d;

    // Idle counter: counts RUN cycles without a valid beat, cleared otherwise.
    always_comb begin
        idle_d = '0;
        if (!i_start && state_q == ST_RUN && !i_vld) begin
            idle_d = idle_q + IDLE_W'(1);
        end
        idle_expired = !i_start && (state_q == ST_RUN) && !i_vld &&
                       (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1));
    end

    // Idle counter register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) idle_q <= '0;
        else       idle_q <= idle_d;
    end
`else
    assign idle_expired = 1'b0;
`endif

    // Next-state and datapath control; i_start has priority in every state.
    always_comb begin
        state_d   = state_q;
        sig_d     = sig_q;
        count_d   = count_q;
        done_d    = done_q;
        pass_d    = pass_q;
        timeout_d = timeout_q;
        if (i_start) begin
            sig_d     = i_seed;
            count_d   = '0;
            done_d    = 1'b0;
            pass_d    = 1'b0;
            timeout_d = 1'b0;
            state_d   = ST_RUN;
        end else begin
            unique case (state_q)
                ST_IDLE: ;
                ST_RUN: begin
                    if (i_vld) begin
                        sig_d = sig_next;
                        if (count_q != '1) count_d = count_q + CNT_W'(1);
                        if (i_last) state_d = ST_CHECK;
                    end else if (idle_expired) begin
                        timeout_d = 1'b1;
                        done_d    = 1'b1;
                        pass_d    = 1'b0;
                        state_d   = ST_DONE;
                    end
                end
                ST_CHECK: begin
                    pass_d  = (sig_q == i_expected);
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
                ST_DONE: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and result registers; reset discards any partial signature.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            sig_q     <= '0;
            count_q   <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sig_q     <= sig_d;
            count_q   <= count_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            timeout_q <= timeout_d;
        end
    end

    // Output mapping; without the watchdog the timeout flag is constant 0.
    always_comb begin
        o_busy      = (state_q == ST_RUN) || (state_q == ST_CHECK);
        o_done      = done_q;
        o_pass      = pass_q;
        o_signature = sig_q;
        o_count     = count_q;
`ifdef MISR_TIMEOUT_EN
        o_timeout   = timeout_q;
`else
        o_timeout   = 1'b0;
`endif
    end

endmodule
